// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg : arbiter state encoding and round-robin pick helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } arb_state_t;

  // The helper works on a fixed-width vector, so at most 32 requesters are supported.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   elig,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned         nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned off = 0; off < RR_MAX; off++) begin
      cand = (32'(ptr) + off) % nreq;
      if (off < nreq && !res.found && elig[cand[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/d_ff.sv
// ---------------------------------------------------------------------------
// d_ff : N-bit enabled register with synchronous active-high clear
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module d_ff #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] in_d,
  output logic [N-1:0] out_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= in_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter : round-robin writer arbitration for one shared register,
//                     with locked bursts of up to HOLD_MAX writes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int R        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   lock,
  input  logic [R*N-1:0] wdata,
  output logic [R-1:0]   gnt,
  output logic           busy,
  output logic [N-1:0]   out_q
);

  localparam int PTR_W = (R > 1) ? $clog2(R) : 1;
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  arb_state_t        state_q, state_d;
  logic [R-1:0]      gnt_q, gnt_d;
  logic [PTR_W-1:0]  own_q, own_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [N-1:0]      wr_data_q, wr_data_d;
  logic              busy_q;

  logic [N-1:0]      word [R];
  logic [R-1:0]      eligible;
  logic [RR_MAX-1:0] elig_ext;
  rr_pick_t          pick;
  logic [PTR_W-1:0]  win;
  logic              hold_burst;

  for (genvar gi = 0; gi < R; gi++) begin : g_word
    assign word[gi] = wdata[gi*N +: N];
  end

  always_comb begin
    state_d   = IDLE;
    gnt_d     = '0;
    own_d     = own_q;
    ptr_d     = ptr_q;
    cnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;

    // gnt_q is zero in IDLE, so it doubles as the one-decision mask.
    eligible             = req & ~gnt_q;
    elig_ext             = '0;
    elig_ext[R-1:0]      = eligible;
    pick                 = rr_pick(elig_ext, RR_IDX_W'(ptr_q), R);
    win                  = PTR_W'(pick.idx);
    hold_burst           = (state_q == BURST) && req[own_q] && lock[own_q] &&
                           (cnt_q < CNT_W'(HOLD_MAX));

    if (hold_burst) begin
      state_d   = BURST;
      gnt_d     = gnt_q;
      wr_en_d   = 1'b1;
      wr_data_d = word[own_q];
      cnt_d     = cnt_q + CNT_W'(1);
    end else if (pick.found) begin
      gnt_d[win] = 1'b1;
      own_d      = win;
      wr_en_d    = 1'b1;
      wr_data_d  = word[win];
      ptr_d      = (win == PTR_W'(R - 1)) ? '0 : PTR_W'(win + PTR_W'(1));
      if (lock[win]) begin
        state_d = BURST;
        cnt_d   = CNT_W'(1);
      end else begin
        state_d = GRANT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

  d_ff #(.N(N)) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (wr_en_q),
    .in_d  (wr_data_q),
    .out_q (out_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter : directed literal checks plus randomized run compared
//                        cycle-by-cycle against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg_write_arbiter;

  localparam int N    = 8;
  localparam int R    = 4;
  localparam int HOLD = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [R-1:0]   req;
  logic [R-1:0]   lock;
  logic [R*N-1:0] wdata;
  logic [R-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   out_q;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(.N(N), .R(R), .HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .busy  (busy),
    .out_q (out_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_word(input int i, input logic [N-1:0] v);
    wdata[i*N +: N] = v;
  endtask

  task automatic lit(input string name, input logic [R-1:0] eg, input logic eb,
                     input logic [N-1:0] eo);
    chk({name, ".gnt"},  32'(gnt),   32'(eg));
    chk({name, ".busy"}, 32'(busy),  32'(eb));
    chk({name, ".out"},  32'(out_q), 32'(eo));
  endtask

  // Behavioural model: current grantee (-1 none), burst tally, rotating pointer,
  // and a pending write that lands in the register one edge after its grant.
  bit           m_valid = 1'b0;
  int           m_g, m_cnt, m_ptr;
  bit           m_burst, m_en;
  logic [N-1:0] m_data, m_out;

  task automatic model_step();
    int nw;
    int idx;
    if (reset) begin
      m_valid = 1'b1;
      m_g = -1; m_cnt = 0; m_ptr = 0; m_burst = 0; m_en = 0;
      m_data = '0; m_out = '0;
    end else if (m_valid) begin
      if (m_en) m_out = m_data;
      if (m_burst && m_g >= 0 && req[m_g] && lock[m_g] && m_cnt < HOLD) begin
        m_cnt++;
        m_en   = 1;
        m_data = wdata[m_g*N +: N];
      end else begin
        nw = -1;
        for (int k = 0; k < R; k++) begin
          idx = (m_ptr + k) % R;
          if (nw < 0 && req[idx] && idx != m_g) nw = idx;
        end
        m_g = nw;
        if (nw >= 0) begin
          m_en    = 1;
          m_data  = wdata[nw*N +: N];
          m_ptr   = (nw + 1) % R;
          m_burst = lock[nw];
          m_cnt   = 1;
        end else begin
          m_en = 0; m_burst = 0; m_cnt = 0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [R-1:0] eg;
    model_step();
    #1;
    if (m_valid) begin
      eg = '0;
      if (m_g >= 0) eg[m_g] = 1'b1;
      chk("model.gnt",  32'(gnt),   32'(eg));
      chk("model.busy", 32'(busy),  32'(m_g >= 0));
      chk("model.out",  32'(out_q), 32'(m_out));
    end
  end

  initial begin
    reset = 1'b1; req = 4'hF; lock = '0; wdata = '0;

    // Reset held with all requests high
    tick(); lit("rst1", 4'b0000, 1'b0, 8'h00);
    tick(); lit("rst2", 4'b0000, 1'b0, 8'h00);
    reset = 1'b0; req = '0;
    tick(); lit("rst3", 4'b0000, 1'b0, 8'h00);

    // Single unlocked write
    req = 4'b0100; set_word(2, 8'h5A);
    tick(); lit("single1", 4'b0100, 1'b1, 8'h00);
    req = '0;
    tick(); lit("single2", 4'b0000, 1'b0, 8'h5A);

    // Rotation from ptr=0
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'hF;
    tick(); chk("rot0", 32'(gnt), 32'h1);
    tick(); chk("rot1", 32'(gnt), 32'h2);
    tick(); chk("rot2", 32'(gnt), 32'h4);
    tick(); chk("rot3", 32'(gnt), 32'h8);
    tick(); chk("rot4", 32'(gnt), 32'h1);
    req = '0; tick();

    // Burst cap with a competing requester
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0010; lock = 4'b0010; set_word(1, 8'h10); set_word(3, 8'h33);
    tick(); lit("cap1", 4'b0010, 1'b1, 8'h00);
    req = 4'b1010; set_word(1, 8'h11);
    tick(); lit("cap2", 4'b0010, 1'b1, 8'h10);
    set_word(1, 8'h12);
    tick(); lit("cap3", 4'b0010, 1'b1, 8'h11);
    set_word(1, 8'h13);
    tick(); lit("cap4", 4'b0010, 1'b1, 8'h12);
    set_word(1, 8'h14);
    tick(); lit("cap5", 4'b1000, 1'b1, 8'h13);
    req = '0; lock = '0;
    tick(); lit("cap6", 4'b0000, 1'b0, 8'h33);

    // Burst released early by dropping lock
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0101; lock = 4'b0001; set_word(0, 8'hA0); set_word(2, 8'hC2);
    tick(); chk("rel1", 32'(gnt), 32'h1);
    set_word(0, 8'hA1);
    tick(); chk("rel2", 32'(gnt), 32'h1);
    req = 4'b0100; lock = '0;
    tick(); lit("rel3", 4'b0100, 1'b1, 8'hA1);
    req = '0;
    tick(); lit("rel4", 4'b0000, 1'b0, 8'hC2);

    // Reset during the second burst grant
    req = 4'b0001; lock = 4'b0001; set_word(0, 8'hB0);
    tick(); chk("mid1", 32'(gnt), 32'h1);
    set_word(0, 8'hB1);
    tick(); chk("mid2", 32'(gnt), 32'h1);
    reset = 1'b1;
    tick(); lit("mid3", 4'b0000, 1'b0, 8'h00);
    reset = 1'b0; req = 4'hF; lock = '0;
    tick(); chk("mid4", 32'(gnt), 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1)
        req = R'($urandom);
      else
        req = (req & ~gnt) | (R'($urandom) & R'($urandom));
      lock  = ($urandom_range(0, 3) != 0) ? req : R'($urandom);
      wdata = $urandom;
      tick();
    end

    reset = 1'b0; req = '0; lock = '0;
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
